// File: rtl/attn_pkg.sv
// attn_pkg: shared definitions for the attention-score datapath.
//   state_t  - sequencer states of attn_score_engine
//   clog2    - ceiling log2, usable in parameter expressions
//   sat_max  - largest signed value representable in a given width
//   sat_min  - smallest signed value representable in a given width
// The limit functions return a wide signed value. Users size-cast the
// result to their own datapath width.
package attn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Wide enough for any realistic accumulator/result width.
    localparam int unsigned LIM_W = 128;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    function automatic logic signed [LIM_W-1:0] sat_max(input int unsigned ow);
        logic signed [LIM_W-1:0] one;
        one = 1;
        return (one <<< (ow - 1)) - one;
    endfunction

    function automatic logic signed [LIM_W-1:0] sat_min(input int unsigned ow);
        logic signed [LIM_W-1:0] one;
        one = 1;
        return -(one <<< (ow - 1));
    endfunction

endpackage

// File: rtl/attn_sat_shift.sv
// attn_sat_shift: combinational arithmetic right shift followed by a
// signed saturation to OW bits.
//   sum       in  AW  signed full-precision sum
//   shift     in  SW  right-shift amount; floor rounding (toward -inf)
//   res       out OW  shifted value clamped to [-2^(OW-1), 2^(OW-1)-1]
//   saturated out 1   high when res was clamped
module attn_sat_shift
    import attn_pkg::*;
#(
    parameter int AW = 66,
    parameter int OW = 32,
    parameter int SW = clog2(AW)
) (
    input  logic signed [AW-1:0] sum,
    input  logic        [SW-1:0] shift,
    output logic signed [OW-1:0] res,
    output logic                 saturated
);

    localparam logic signed [AW-1:0] HI = AW'(sat_max(OW));
    localparam logic signed [AW-1:0] LO = AW'(sat_min(OW));

    logic signed [AW-1:0] shifted;

    always_comb begin
        // >>> on a signed operand replicates the sign bit, which gives floor
        // rounding for negative sums.
        shifted   = sum >>> shift;
        res       = shifted[OW-1:0];
        saturated = 1'b0;
        if (shifted > HI) begin
            res       = HI[OW-1:0];
            saturated = 1'b1;
        end else if (shifted < LO) begin
            res       = LO[OW-1:0];
            saturated = 1'b1;
        end
    end

endmodule

// File: rtl/attn_score_engine.sv
// attn_score_engine: DIMxDIM signed matrix multiplier for attention
// scores. It computes C = A*B or C = A*B^T with one MAC per cycle. Each
// finished element is shifted once and saturated to OW bits.
//   clk                 clock, all state on rising edge
//   rst                 asynchronous active-low reset
//   a_we/a_row/a_col/a_data  A write port (accepted in IDLE only)
//   b_we/b_row/b_col/b_data  B write port (accepted in IDLE only)
//   start               begin a run (sampled in IDLE only)
//   transpose_b         1: C=A*B^T, 0: C=A*B; latched with start
//   shift               per-element arithmetic right shift; latched with start
//   busy                high while computing
//   done                one-cycle pulse on the edge that writes the last element
//   sat_flag            sticky: some element of the last run was clamped
//   rd_row/rd_col       C read index
//   rd_data             C[rd_row][rd_col], registered (one cycle latency)
module attn_score_engine
    import attn_pkg::*;
#(
    parameter  int DIM = 4,
    parameter  int DW  = 32,
    parameter  int OW  = 32,
    localparam int AW  = 2 * DW + clog2(DIM),
    localparam int IW  = clog2(DIM),
    localparam int SW  = clog2(AW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_we,
    input  logic        [IW-1:0] a_row,
    input  logic        [IW-1:0] a_col,
    input  logic signed [DW-1:0] a_data,
    input  logic                 b_we,
    input  logic        [IW-1:0] b_row,
    input  logic        [IW-1:0] b_col,
    input  logic signed [DW-1:0] b_data,
    input  logic                 start,
    input  logic                 transpose_b,
    input  logic        [SW-1:0] shift,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag,
    input  logic        [IW-1:0] rd_row,
    input  logic        [IW-1:0] rd_col,
    output logic signed [OW-1:0] rd_data
);

    localparam logic [IW-1:0] LAST = IW'(DIM - 1);

    logic signed [DW-1:0] a_mem [DIM][DIM];
    logic signed [DW-1:0] b_mem [DIM][DIM];
    logic signed [OW-1:0] c_mem [DIM][DIM];

    state_t               state;
    logic        [IW-1:0] i_idx;
    logic        [IW-1:0] j_idx;
    logic        [IW-1:0] k_idx;
    logic signed [AW-1:0] acc;
    logic                 transpose_q;
    logic        [SW-1:0] shift_q;

    logic signed [DW-1:0]   a_op;
    logic signed [DW-1:0]   b_op;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc_next;
    logic signed [OW-1:0]   elem;
    logic                   elem_sat;

    always_comb begin
        a_op     = a_mem[i_idx][k_idx];
        b_op     = transpose_q ? b_mem[j_idx][k_idx] : b_mem[k_idx][j_idx];
        prod     = a_op * b_op;
        acc_next = acc + {{(AW - 2 * DW){prod[2*DW-1]}}, prod};
    end

    attn_sat_shift #(
        .AW(AW),
        .OW(OW),
        .SW(SW)
    ) u_sat_shift (
        .sum      (acc_next),
        .shift    (shift_q),
        .res      (elem),
        .saturated(elem_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            sat_flag    <= 1'b0;
            rd_data     <= '0;
            a_mem       <= '{default: '0};
            b_mem       <= '{default: '0};
            c_mem       <= '{default: '0};
            acc         <= '0;
            i_idx       <= '0;
            j_idx       <= '0;
            k_idx       <= '0;
            transpose_q <= 1'b0;
            shift_q     <= '0;
        end else begin
            // The read port samples c_mem before this edge's write lands,
            // so a same-cycle read of the element being written returns the old value.
            rd_data <= c_mem[rd_row][rd_col];
            done    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (a_we) a_mem[a_row][a_col] <= a_data;
                    if (b_we) b_mem[b_row][b_col] <= b_data;
                    if (start) begin
                        transpose_q <= transpose_b;
                        shift_q     <= shift;
                        sat_flag    <= 1'b0;
                        i_idx       <= '0;
                        j_idx       <= '0;
                        k_idx       <= '0;
                        acc         <= '0;
                        busy        <= 1'b1;
                        state       <= ST_COMPUTE;
                    end
                end

                ST_COMPUTE: begin
                    if (k_idx == LAST) begin
                        // The final term goes straight into the shift/saturate
                        // path, so acc never holds a finished sum and restarts at zero.
                        c_mem[i_idx][j_idx] <= elem;
                        if (elem_sat) sat_flag <= 1'b1;
                        acc   <= '0;
                        k_idx <= '0;
                        if (j_idx == LAST) begin
                            j_idx <= '0;
                            if (i_idx == LAST) begin
                                i_idx <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                i_idx <= i_idx + 1'b1;
                            end
                        end else begin
                            j_idx <= j_idx + 1'b1;
                        end
                    end else begin
                        acc   <= acc_next;
                        k_idx <= k_idx + 1'b1;
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_score_engine.sv
// tb_attn_score_engine: self-checking bench for attn_score_engine. A
// matrix-level reference model computes expected C and sat_flag values.
// Operands come from directed patterns and from $urandom.
module tb_attn_score_engine;

    localparam int DIM = 4;
    localparam int DW  = 32;
    localparam int OW  = 32;
    localparam int AW  = 2 * DW + $clog2(DIM);
    localparam int IW  = $clog2(DIM);
    localparam int SW  = $clog2(AW);
    localparam int LAT = DIM * DIM * DIM;

    localparam logic signed [127:0] MAXV = (128'sd1 <<< (OW - 1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (OW - 1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 a_we, b_we;
    logic        [IW-1:0] a_row, a_col, b_row, b_col;
    logic signed [DW-1:0] a_data, b_data;
    logic                 start, transpose_b;
    logic        [SW-1:0] shift;
    logic                 busy, done, sat_flag;
    logic        [IW-1:0] rd_row, rd_col;
    logic signed [OW-1:0] rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [DW-1:0] ma  [DIM][DIM];
    logic signed [DW-1:0] mb  [DIM][DIM];
    logic signed [OW-1:0] mc  [DIM][DIM];
    logic signed [OW-1:0] got [DIM][DIM];
    bit                   msat;

    attn_score_engine #(
        .DIM(DIM),
        .DW (DW),
        .OW (OW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_we       (a_we),
        .a_row      (a_row),
        .a_col      (a_col),
        .a_data     (a_data),
        .b_we       (b_we),
        .b_row      (b_row),
        .b_col      (b_col),
        .b_data     (b_data),
        .start      (start),
        .transpose_b(transpose_b),
        .shift      (shift),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Reference: C = A * op(B), computed in wide signed arithmetic.
    // Each dot product is shifted once and then clamped.
    task automatic model(input bit tr, input int sh);
        logic signed [127:0] s;
        logic signed [127:0] bv;
        msat = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                s = 0;
                for (int k = 0; k < DIM; k++) begin
                    bv = tr ? 128'(mb[j][k]) : 128'(mb[k][j]);
                    s  = s + 128'(ma[i][k]) * bv;
                end
                s = s >>> sh;
                if (s > MAXV) begin
                    mc[i][j] = OW'(MAXV);
                    msat = 1'b1;
                end else if (s < MINV) begin
                    mc[i][j] = OW'(MINV);
                    msat = 1'b1;
                end else begin
                    mc[i][j] = OW'(s);
                end
            end
        end
    endtask

    task automatic load_dut();
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                a_we = 1'b1; a_row = IW'(r); a_col = IW'(c); a_data = ma[r][c];
                b_we = 1'b1; b_row = IW'(r); b_col = IW'(c); b_data = mb[r][c];
                @(posedge clk); #1;
            end
        end
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic read_all();
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                rd_row = IW'(r);
                rd_col = IW'(c);
                @(posedge clk); #1;
                got[r][c] = rd_data;
            end
        end
    endtask

    // Starts a run and measures latency, busy cycles and done pulses.
    // With disturb set, A[0][0] is written and start is pulsed at cycle 10.
    task automatic run_dut(input bit tr, input int sh, input bit disturb,
                           output int lat, output int busy_cnt, output int done_cnt);
        start = 1'b1; transpose_b = tr; shift = SW'(sh);
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        for (int n = 1; n <= LAT + 100; n++) begin
            if (disturb && n == 10) begin
                a_we = 1'b1; a_row = '0; a_col = '0; a_data = 32'hDEAD; start = 1'b1;
            end
            @(posedge clk); #1;
            a_we = 1'b0;
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = n;
            end
            if (busy) busy_cnt++;
            if (lat >= 0 && n >= lat + 4) break;
        end
    endtask

    task automatic fill_identity_a();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                ma[r][c] = (r == c) ? 1 : 0;
    endtask

    task automatic fill_random(input bit wide);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                ma[r][c] = wide ? $urandom : DW'($urandom_range(2000) - 1000);
                mb[r][c] = wide ? $urandom : DW'($urandom_range(2000) - 1000);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL reset_sat: got %b want 0", sat_flag); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_rd: got %0d want 0", rd_data); else n_pass++;
    endtask

    task automatic test_identity();
        int lat, bc, dc;
        fill_identity_a();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                mb[r][c] = 4 * r + c;
        load_dut();
        model(1'b0, 0);
        run_dut(1'b0, 0, 1'b0, lat, bc, dc);
        n_checks++; if (lat !== LAT) $display("FAIL ident_latency: got %0d want %0d", lat, LAT); else n_pass++;
        n_checks++; if (bc !== LAT) $display("FAIL ident_busy_cycles: got %0d want %0d", bc, LAT); else n_pass++;
        n_checks++; if (dc !== 1) $display("FAIL ident_done_pulses: got %0d want 1", dc); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL ident_sat: got %b want 0", sat_flag); else n_pass++;
        read_all();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                n_checks++;
                if (got[r][c] !== mc[r][c] || got[r][c] !== OW'(4 * r + c))
                    $display("FAIL ident_C[%0d][%0d]: got %0d want %0d", r, c, got[r][c], 4 * r + c);
                else n_pass++;
            end
    endtask

    task automatic test_transpose();
        int lat, bc, dc;
        fill_identity_a();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                mb[r][c] = 0;
        mb[0][1] = 5;
        mb[1][0] = 9;
        load_dut();
        model(1'b1, 0);
        run_dut(1'b1, 0, 1'b0, lat, bc, dc);
        n_checks++; if (lat !== LAT) $display("FAIL tr_latency: got %0d want %0d", lat, LAT); else n_pass++;
        read_all();
        n_checks++; if (got[1][0] !== 5) $display("FAIL tr_C10: got %0d want 5", got[1][0]); else n_pass++;
        n_checks++; if (got[0][1] !== 9) $display("FAIL tr_C01: got %0d want 9", got[0][1]); else n_pass++;
        n_checks++; if (got[2][3] !== 0) $display("FAIL tr_C23: got %0d want 0", got[2][3]); else n_pass++;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                n_checks++;
                if (got[r][c] !== mc[r][c])
                    $display("FAIL tr_C[%0d][%0d]: got %0d want %0d", r, c, got[r][c], mc[r][c]);
                else n_pass++;
            end
    endtask

    task automatic test_sign_shift();
        int lat, bc, dc;
        int shifts [3] = '{1, 3, 0};
        int fixed  [3] = '{-6, -2, -12};
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                ma[r][c] = -3;
                mb[r][c] = 1;
            end
        load_dut();
        for (int t = 0; t < 3; t++) begin
            model(1'b0, shifts[t]);
            run_dut(1'b0, shifts[t], 1'b0, lat, bc, dc);
            n_checks++; if (lat !== LAT) $display("FAIL shift%0d_latency: got %0d want %0d", shifts[t], lat, LAT); else n_pass++;
            read_all();
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    n_checks++;
                    if (got[r][c] !== mc[r][c] || got[r][c] !== OW'(fixed[t]))
                        $display("FAIL shift%0d_C[%0d][%0d]: got %0d want %0d", shifts[t], r, c, got[r][c], fixed[t]);
                    else n_pass++;
                end
        end
    endtask

    task automatic test_saturation();
        int lat, bc, dc;
        logic signed [DW-1:0] a_val [2] = '{32'h7FFFFFFF, 32'h80000000};
        logic signed [OW-1:0] c_val [2] = '{32'h7FFFFFFF, 32'h80000000};
        for (int t = 0; t < 2; t++) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    ma[r][c] = a_val[t];
                    mb[r][c] = 32'h7FFFFFFF;
                end
            load_dut();
            model(1'b0, 0);
            run_dut(1'b0, 0, 1'b0, lat, bc, dc);
            n_checks++; if (sat_flag !== 1'b1) $display("FAIL sat%0d_flag: got %b want 1", t, sat_flag); else n_pass++;
            read_all();
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    n_checks++;
                    if (got[r][c] !== mc[r][c] || got[r][c] !== c_val[t])
                        $display("FAIL sat%0d_C[%0d][%0d]: got %h want %h", t, r, c, got[r][c], c_val[t]);
                    else n_pass++;
                end
        end
        fill_identity_a();
        load_dut();
        model(1'b0, 0);
        run_dut(1'b0, 0, 1'b0, lat, bc, dc);
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL sat_clear_flag: got %b want 0", sat_flag); else n_pass++;
        read_all();
        n_checks++; if (got[3][2] !== mc[3][2]) $display("FAIL sat_clear_C32: got %h want %h", got[3][2], mc[3][2]); else n_pass++;
    endtask

    task automatic test_random();
        int lat, bc, dc, sh;
        bit tr;
        for (int t = 0; t < 4; t++) begin
            fill_random(t[0]);
            tr = 1'($urandom_range(1));
            sh = $urandom_range(40);
            load_dut();
            model(tr, sh);
            run_dut(tr, sh, 1'b0, lat, bc, dc);
            n_checks++; if (lat !== LAT) $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, LAT); else n_pass++;
            n_checks++; if (sat_flag !== msat) $display("FAIL rand%0d_sat: got %b want %b", t, sat_flag, msat); else n_pass++;
            read_all();
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    n_checks++;
                    if (got[r][c] !== mc[r][c])
                        $display("FAIL rand%0d_C[%0d][%0d]: got %h want %h", t, r, c, got[r][c], mc[r][c]);
                    else n_pass++;
                end
        end
    endtask

    task automatic test_busy_protect();
        int lat, bc, dc;
        fill_random(1'b0);
        load_dut();
        model(1'b0, 2);
        run_dut(1'b0, 2, 1'b1, lat, bc, dc);
        n_checks++; if (lat !== LAT) $display("FAIL busyp_latency: got %0d want %0d", lat, LAT); else n_pass++;
        n_checks++; if (dc !== 1) $display("FAIL busyp_done_pulses: got %0d want 1", dc); else n_pass++;
        read_all();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                n_checks++;
                if (got[r][c] !== mc[r][c])
                    $display("FAIL busyp_C[%0d][%0d]: got %h want %h", r, c, got[r][c], mc[r][c]);
                else n_pass++;
            end
        // Second run with the same operands exposes any change to A[0][0].
        model(1'b0, 0);
        run_dut(1'b0, 0, 1'b0, lat, bc, dc);
        read_all();
        for (int c = 0; c < DIM; c++) begin
            n_checks++;
            if (got[0][c] !== mc[0][c])
                $display("FAIL busyp_rerun_C[0][%0d]: got %h want %h", c, got[0][c], mc[0][c]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        fill_random(1'b0);
        load_dut();
        model(1'b1, 1);
        start = 1'b1; transpose_b = 1'b0; shift = '0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= LAT + 100; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        n_checks++; if (lat !== LAT) $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT); else n_pass++;
        // Start held through DONE (ignored) and accepted on the IDLE edge.
        start = 1'b1; transpose_b = 1'b1; shift = SW'(1);
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_done_ignores_start: busy %b want 0", busy); else n_pass++;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy %b want 1", busy); else n_pass++;
        lat = -1;
        for (int n = 1; n <= LAT + 100; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        n_checks++; if (lat !== LAT) $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT); else n_pass++;
        read_all();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                n_checks++;
                if (got[r][c] !== mc[r][c])
                    $display("FAIL b2b_C[%0d][%0d]: got %h want %h", r, c, got[r][c], mc[r][c]);
                else n_pass++;
            end
    endtask

    task automatic test_reset_midrun();
        int lat, bc, dc;
        fill_random(1'b1);
        load_dut();
        start = 1'b1; transpose_b = 1'b0; shift = '0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL midrst_sat: got %b want 0", sat_flag); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL midrst_rd: got %h want 0", rd_data); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        read_all();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                n_checks++;
                if (got[r][c] !== '0)
                    $display("FAIL midrst_C[%0d][%0d]: got %h want 0", r, c, got[r][c]);
                else n_pass++;
            end
        fill_random(1'b0);
        load_dut();
        model(1'b0, 0);
        run_dut(1'b0, 0, 1'b0, lat, bc, dc);
        n_checks++; if (lat !== LAT) $display("FAIL midrst_rerun_latency: got %0d want %0d", lat, LAT); else n_pass++;
        read_all();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                n_checks++;
                if (got[r][c] !== mc[r][c])
                    $display("FAIL midrst_rerun_C[%0d][%0d]: got %h want %h", r, c, got[r][c], mc[r][c]);
                else n_pass++;
            end
    endtask

    initial begin
        rst = 1'b0;
        a_we = 1'b0; a_row = '0; a_col = '0; a_data = '0;
        b_we = 1'b0; b_row = '0; b_col = '0; b_data = '0;
        start = 1'b0; transpose_b = 1'b0; shift = '0;
        rd_row = '0; rd_col = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_identity();
        test_transpose();
        test_sign_shift();
        test_saturation();
        test_random();
        test_busy_protect();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
